// File: rtl/lsq_arb_pkg.sv
// Shared types for the load/store memory arbiter: ceil-log2 helper, port-ID
// width and the response FIFO entry layout.
// Entry data is sized for the widest supported DATA_SIZE (64); narrower
// instances zero-extend, and the unused upper bits are constant.
package lsq_arb_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Supports up to 16 load requesters.
  localparam int LSQ_ARB_MAX_LOAD_PORTS = 16;
  localparam int PORT_ID_W              = clog2(LSQ_ARB_MAX_LOAD_PORTS);
  localparam int LSQ_ARB_MAX_DATA       = 64;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    port_id_t                    id;
    logic [LSQ_ARB_MAX_DATA-1:0] dat;
  } resp_entry_t;

endpackage

// File: rtl/lsq_arb_fifo.sv
// Purpose: generic synchronous FIFO with simultaneous push/pop.
// Latency: pushed entry visible at head_dat on the next cycle.
// Backpressure: none internally; push when full (without pop) and pop when
//   empty are dropped, and callers use count as their credit.
// Ports: clk/rst (sync, active-high), push/push_dat, pop/head_dat, count.
module lsq_arb_fifo
  import lsq_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO may still accept a push in the same cycle as a pop.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Purpose: arbitrate load/store requesters onto one memory port and route
//   in-order read data back to the issuing load port.
// Latency: request issue 0 cycles (combinational grant); response visible
//   1 cycle after mem_rdata_valid.
// Backpressure: mem_req_ready gates every requester ready; loads are masked
//   when in-flight loads plus buffered responses reach DEPTH; read data has
//   no backpressure, and responses wait in the FIFO for load_data_ready.
// Ports: clk, rst (sync active-high); load_* request/response buses (port i
//   at slice i); store_* request buses; mem_* single memory port.
// Build option: define LSQ_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//   otherwise fixed priority, lowest index first, and no pointer register.
module lsq_mem_arbiter
  import lsq_arb_pkg::*;
#(
  parameter int LOAD_PORTS   = 2,
  parameter int STORE_PORTS  = 1,
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int DEPTH        = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LOAD_PORTS*ADDRESS_SIZE-1:0] load_addr_bus,
  input  logic [LOAD_PORTS-1:0]              load_valid_bus,
  output logic [LOAD_PORTS-1:0]              load_ready_bus,
  output logic [LOAD_PORTS*DATA_SIZE-1:0]    load_data_bus,
  output logic [LOAD_PORTS-1:0]              load_data_valid_bus,
  input  logic [LOAD_PORTS-1:0]              load_data_ready_bus,
  input  logic [STORE_PORTS*ADDRESS_SIZE-1:0] store_addr_bus,
  input  logic [STORE_PORTS*DATA_SIZE-1:0]   store_data_bus,
  input  logic [STORE_PORTS-1:0]             store_valid_bus,
  output logic [STORE_PORTS-1:0]             store_ready_bus,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic                               mem_we,
  output logic [ADDRESS_SIZE-1:0]            mem_addr,
  output logic [DATA_SIZE-1:0]               mem_wdata,
  input  logic [DATA_SIZE-1:0]               mem_rdata,
  input  logic                               mem_rdata_valid
);

  localparam int TOTAL = LOAD_PORTS + STORE_PORTS;
  localparam int GW    = (clog2(TOTAL) < 1) ? 1 : clog2(TOTAL);
  localparam int CW    = clog2(DEPTH) + 1;
  localparam int EW    = $bits(resp_entry_t);

  logic [TOTAL-1:0] req;
  logic             credit_ok;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    resp_count;
  logic             gnt_vld;
  logic [GW-1:0]    gnt_idx;
  port_id_t         gnt_id;
  logic             hs;
  logic             load_hs;
  logic             ret;
  port_id_t         id_head;
  resp_entry_t      resp_in;
  resp_entry_t      resp_head;
  logic             resp_pop;

  // The in-flight count is the ID queue occupancy; every issued load owns
  // one ID slot and, later, one response slot, so their sum is the credit.
  assign credit_ok = ({1'b0, inflight} + {1'b0, resp_count}) < (CW+1)'(DEPTH);
  assign req       = {store_valid_bus, load_valid_bus & {LOAD_PORTS{credit_ok}}};

`ifdef LSQ_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr;

  // First requester at or after rr_ptr, wrapping around the vector.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < TOTAL; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= TOTAL) cand = cand - TOTAL;
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (gnt_idx == GW'(TOTAL-1)) ? '0 : gnt_idx + GW'(1);
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest index granted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = TOTAL-1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(i);
      end
    end
  end
`endif

  // Memory request mux; everything is forced idle while rst is high.
  always_comb begin
    mem_req_valid   = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    load_ready_bus  = '0;
    store_ready_bus = '0;
    gnt_id          = '0;
    if (gnt_vld && !rst) begin
      mem_req_valid = 1'b1;
      for (int i = 0; i < LOAD_PORTS; i++) begin
        if (gnt_idx == GW'(i)) begin
          mem_addr          = load_addr_bus[i*ADDRESS_SIZE +: ADDRESS_SIZE];
          load_ready_bus[i] = mem_req_ready;
          gnt_id            = port_id_t'(i);
        end
      end
      for (int s = 0; s < STORE_PORTS; s++) begin
        if (gnt_idx == GW'(LOAD_PORTS + s)) begin
          mem_we             = 1'b1;
          mem_addr           = store_addr_bus[s*ADDRESS_SIZE +: ADDRESS_SIZE];
          mem_wdata          = store_data_bus[s*DATA_SIZE +: DATA_SIZE];
          store_ready_bus[s] = mem_req_ready;
        end
      end
    end
  end

  assign hs      = mem_req_valid && mem_req_ready;
  assign load_hs = hs && !mem_we;
  // Read data with nothing outstanding (e.g. loads dropped by a reset) is
  // a protocol error and is ignored.
  assign ret     = mem_rdata_valid && (inflight != '0) && !rst;

  assign resp_in.id  = id_head;
  assign resp_in.dat = LSQ_ARB_MAX_DATA'(mem_rdata);

  lsq_arb_fifo #(
    .WIDTH (PORT_ID_W),
    .DEPTH (DEPTH)
  ) u_id_q (
    .clk      (clk),
    .rst      (rst),
    .push     (load_hs),
    .push_dat (gnt_id),
    .pop      (ret),
    .head_dat (id_head),
    .count    (inflight)
  );

  lsq_arb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_resp_q (
    .clk      (clk),
    .rst      (rst),
    .push     (ret),
    .push_dat (resp_in),
    .pop      (resp_pop),
    .head_dat (resp_head),
    .count    (resp_count)
  );

  // Only the owning port sees the response head; only that port may pop it.
  always_comb begin
    load_data_bus       = '0;
    load_data_valid_bus = '0;
    resp_pop            = 1'b0;
    if ((resp_count != '0) && !rst) begin
      for (int i = 0; i < LOAD_PORTS; i++) begin
        if (resp_head.id == port_id_t'(i)) begin
          load_data_valid_bus[i]                   = 1'b1;
          load_data_bus[i*DATA_SIZE +: DATA_SIZE]  = DATA_SIZE'(resp_head.dat);
          resp_pop                                 = load_data_ready_bus[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Bench for lsq_mem_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_lsq_mem_arbiter;

  localparam int LP    = 2;
  localparam int SP    = 1;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TOT   = LP + SP;

  logic              clk = 1'b0;
  logic              rst;
  logic [LP*AW-1:0]  load_addr_bus;
  logic [LP-1:0]     load_valid_bus;
  logic [LP-1:0]     load_ready_bus;
  logic [LP*DW-1:0]  load_data_bus;
  logic [LP-1:0]     load_data_valid_bus;
  logic [LP-1:0]     load_data_ready_bus;
  logic [SP*AW-1:0]  store_addr_bus;
  logic [SP*DW-1:0]  store_data_bus;
  logic [SP-1:0]     store_valid_bus;
  logic [SP-1:0]     store_ready_bus;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_rdata_valid;

  lsq_mem_arbiter #(
    .LOAD_PORTS(LP), .STORE_PORTS(SP), .DATA_SIZE(DW),
    .ADDRESS_SIZE(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .load_addr_bus(load_addr_bus), .load_valid_bus(load_valid_bus),
    .load_ready_bus(load_ready_bus), .load_data_bus(load_data_bus),
    .load_data_valid_bus(load_data_valid_bus),
    .load_data_ready_bus(load_data_ready_bus),
    .store_addr_bus(store_addr_bus), .store_data_bus(store_data_bus),
    .store_valid_bus(store_valid_bus), .store_ready_bus(store_ready_bus),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding load port IDs, buffered responses,
  // outstanding reads at the memory, round-robin pointer.
  int          m_infl[$];
  int          m_rport[$];
  logic [DW-1:0] m_rdat[$];
  int          m_pend = 0;
  int          m_ptr  = 0;

  // Observations of the last cycle for directed checks.
  logic [63:0] s_gnt;
  logic [63:0] s_lrdy;
  logic [63:0] s_ldv;
  logic [63:0] s_ldat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    bit credit;
    bit r[TOT];
    credit = (m_infl.size() + m_rport.size()) < DEPTH;
    for (int i = 0; i < LP; i++) r[i] = load_valid_bus[i] && credit;
    for (int s = 0; s < SP; s++) r[LP+s] = store_valid_bus[s];
`ifdef LSQ_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < TOT; k++) if (r[(m_ptr+k)%TOT]) return (m_ptr+k)%TOT;
`else
    for (int k = 0; k < TOT; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven: checks the
  // outputs, advances the model for the coming rising edge, waits one cycle.
  task automatic cycle();
    int g;
    logic [63:0] e_lrdy, e_srdy, e_ldv, e_ldat;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    #1;
    g = rst ? -1 : exp_grant();
    e_addr = '0; e_wdata = '0; e_lrdy = '0; e_srdy = '0;
    if (g >= 0 && g < LP) begin
      e_addr = load_addr_bus[g*AW +: AW];
      if (mem_req_ready) e_lrdy = 64'(1) << g;
    end
    if (g >= LP) begin
      e_addr  = store_addr_bus[(g-LP)*AW +: AW];
      e_wdata = store_data_bus[(g-LP)*DW +: DW];
      if (mem_req_ready) e_srdy = 64'(1) << (g-LP);
    end
    e_ldv = '0; e_ldat = '0;
    if (!rst && m_rport.size() > 0) begin
      e_ldv  = 64'(1) << m_rport[0];
      e_ldat = 64'(m_rdat[0]) << (m_rport[0]*DW);
    end
    chk("req_vld", 64'(mem_req_valid), 64'(g >= 0));
    chk("we",      64'(mem_we),        64'(g >= LP));
    chk("addr",    64'(mem_addr),      64'(e_addr));
    chk("wdata",   64'(mem_wdata),     64'(e_wdata));
    chk("lrdy",    64'(load_ready_bus),  e_lrdy);
    chk("srdy",    64'(store_ready_bus), e_srdy);
    chk("ldv",     64'(load_data_valid_bus), e_ldv);
    chk("ldat",    64'(load_data_bus),       e_ldat);
    s_gnt  = {59'd0, store_ready_bus, load_ready_bus, 2'b00} >> 2;
    s_lrdy = 64'(load_ready_bus);
    s_ldv  = 64'(load_data_valid_bus);
    s_ldat = 64'(load_data_bus);
    if (rst) begin
      m_infl.delete(); m_rport.delete(); m_rdat.delete();
      m_pend = 0; m_ptr = 0;
    end else begin
      if (m_rport.size() > 0 && load_data_ready_bus[m_rport[0]]) begin
        void'(m_rport.pop_front());
        void'(m_rdat.pop_front());
      end
      if (mem_rdata_valid && m_infl.size() > 0) begin
        m_rport.push_back(m_infl.pop_front());
        m_rdat.push_back(mem_rdata);
      end
      if (mem_rdata_valid && m_pend > 0) m_pend--;
      if (g >= 0 && mem_req_ready) begin
        if (g < LP) begin
          m_infl.push_back(g);
          m_pend++;
        end
        m_ptr = (g + 1) % TOT;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    load_addr_bus = '0; load_valid_bus = '0; load_data_ready_bus = '0;
    store_addr_bus = '0; store_data_bus = '0; store_valid_bus = '0;
    mem_req_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Return everything outstanding and let every port consume it.
  task automatic drain();
    idle();
    load_data_ready_bus = '1;
    for (int k = 0; k < 3*DEPTH; k++) begin
      mem_rdata_valid = (m_pend > 0);
      mem_rdata       = $urandom;
      cycle();
    end
    idle();
  endtask

`ifdef LSQ_ARB_ROUND_ROBIN_EN
  int order_exp[4] = '{0, 1, 2, 0};
`else
  int order_exp[5] = '{0, 0, 0, 0, 2};
`endif

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // Idle after reset: nothing valid, nothing ready.
    cycle();
    chk("idle_gnt", s_gnt, 64'd0);
    chk("idle_ldv", s_ldv, 64'd0);

    // Single load on port 0, data returned the next cycle.
    load_valid_bus = 2'b01; load_addr_bus[AW-1:0] = 32'h10; mem_req_ready = 1'b1;
    cycle();
    chk("l0_issue", s_lrdy, 64'd1);
    idle();
    mem_rdata_valid = 1'b1; mem_rdata = 32'hAB;
    cycle();
    chk("l0_not_yet", s_ldv, 64'd0);
    idle();
    load_data_ready_bus = 2'b01;
    cycle();
    chk("l0_ret_vld", s_ldv, 64'd1);
    chk("l0_ret_dat", s_ldat, 64'hAB);
    drain();

    // All requesters valid continuously: grant order.
    do_reset();
    load_valid_bus = 2'b11; store_valid_bus = 1'b1; mem_req_ready = 1'b1;
    load_addr_bus = {32'h200, 32'h100}; store_addr_bus = 32'h300; store_data_bus = 32'hCAFE;
    foreach (order_exp[k]) begin
      cycle();
      chk("gnt_order", s_gnt, 64'(1) << order_exp[k]);
    end
    drain();

    // Credit exhaustion with a stalled consumer.
    do_reset();
    load_valid_bus = 2'b01; mem_req_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      load_addr_bus[AW-1:0] = 32'h40 + 32'(4*k);
      cycle();
      chk("fill_issue", s_lrdy, 64'd1);
    end
    cycle();
    chk("fill_block", s_lrdy, 64'd0);
    load_valid_bus = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem_rdata_valid = 1'b1; mem_rdata = 32'(k + 1);
      cycle();
    end
    mem_rdata_valid = 1'b0; load_valid_bus = 2'b01;
    cycle();
    chk("buf_block", s_lrdy, 64'd0);
    load_data_ready_bus = 2'b01;
    cycle();
    chk("pop_cycle_block", s_lrdy, 64'd0);
    load_data_ready_bus = 2'b00;
    cycle();
    chk("credit_back", s_lrdy, 64'd1);
    drain();

    // Responses routed by issue order, not by port number.
    do_reset();
    mem_req_ready = 1'b1; load_data_ready_bus = 2'b11;
    load_valid_bus = 2'b10; load_addr_bus = {32'h20, 32'h0};
    cycle();
    chk("ord_l1", s_lrdy, 64'd2);
    load_valid_bus = 2'b01; load_addr_bus = {32'h0, 32'h24};
    mem_rdata_valid = 1'b1; mem_rdata = 32'h11;
    cycle();
    chk("ord_l0", s_lrdy, 64'd1);
    load_valid_bus = 2'b00; mem_rdata = 32'h22;
    cycle();
    chk("ord_p1_vld", s_ldv, 64'd2);
    chk("ord_p1_dat", s_ldat, 64'h11 << 32);
    mem_rdata_valid = 1'b0;
    cycle();
    chk("ord_p0_vld", s_ldv, 64'd1);
    chk("ord_p0_dat", s_ldat, 64'h22);
    drain();

    // Reset with loads in flight drops them; late read data is ignored.
    do_reset();
    mem_req_ready = 1'b1; load_valid_bus = 2'b11; load_addr_bus = {32'h8, 32'h4};
    cycle();
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    load_data_ready_bus = 2'b00;
    for (int k = 0; k < 2; k++) begin
      mem_rdata_valid = 1'b1; mem_rdata = 32'h77;
      cycle();
    end
    mem_rdata_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_drop_ldv", s_ldv, 64'd0);
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst                 = ($urandom_range(0, 299) == 0);
      load_valid_bus      = LP'($urandom);
      store_valid_bus     = SP'($urandom);
      load_addr_bus       = {$urandom, $urandom};
      store_addr_bus      = $urandom;
      store_data_bus      = $urandom;
      mem_req_ready       = ($urandom_range(0, 3) != 0);
      load_data_ready_bus = LP'($urandom);
      mem_rdata           = $urandom;
      if (m_pend > 0) mem_rdata_valid = $urandom_range(0, 1) == 1;
      else            mem_rdata_valid = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsq_mem_arbiter.md
LSQ_MEM_ARBITER -- requirements
Module: lsq_mem_arbiter

Interface
REQ-001 SHALL have parameter LOAD_PORTS, default 2, number of load requesters.
REQ-002 SHALL have parameter STORE_PORTS, default 1, number of store requesters.
REQ-003 SHALL have parameter DATA_SIZE, default 32, data width.
REQ-004 SHALL have parameter ADDRESS_SIZE, default 32, address width.
REQ-005 SHALL have parameter DEPTH, default 4, maximum loads in flight plus buffered responses; power of two, at least 2.
REQ-006 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_addr_bus  in  LOAD_PORTS*ADDRESS_SIZE  load addresses, port i at slice i.
- load_valid_bus  in  LOAD_PORTS  load request valid.
- load_ready_bus  out  LOAD_PORTS  load request accepted.
- load_data_bus  out  LOAD_PORTS*DATA_SIZE  returned load data.
- load_data_valid_bus  out  LOAD_PORTS  returned data valid.
- load_data_ready_bus  in  LOAD_PORTS  consumer ready.
- store_addr_bus  in  STORE_PORTS*ADDRESS_SIZE  store addresses.
- store_data_bus  in  STORE_PORTS*DATA_SIZE  store data.
- store_valid_bus  in  STORE_PORTS  store address and data both valid.
- store_ready_bus  out  STORE_PORTS  store accepted.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDRESS_SIZE  request address.
- mem_wdata  out  DATA_SIZE  store data.
- mem_rdata  in  DATA_SIZE  read data, in request order.
- mem_rdata_valid  in  1  read data present; no backpressure.

Function
REQ-007 SHALL treat requesters as one vector: loads at indices 0..LOAD_PORTS-1, stores at LOAD_PORTS..LOAD_PORTS+STORE_PORTS-1.
REQ-008 SHALL mask load requesters when the sum of in-flight loads and FIFO occupancy equals DEPTH (no credit).
REQ-009 SHALL grant at most one unmasked valid requester per cycle and drive mem_req_valid, mem_we, mem_addr, and mem_wdata combinationally from the granted requester.
REQ-010 SHALL assert the granted requester's ready only when mem_req_ready=1; a handshake occurs on valid&ready.
REQ-011 SHALL hold all ready outputs at 0 when there is no grant, and drive mem_wdata to 0 on loads.
REQ-012 SHALL, on each load handshake, increment the in-flight count and push the requester index into a port-ID queue of DEPTH entries.
REQ-013 SHALL, on mem_rdata_valid, write {port ID queue head, mem_rdata} into the response FIFO, pop the ID queue, and decrement the in-flight count.
REQ-014 SHALL present the response FIFO head on load_data_bus slice and load_data_valid_bus bit of its port ID only, and pop the head on that port's load_data_ready.
REQ-015 SHALL keep load issue latency at 0 cycles (combinational grant) and response latency at 1 cycle (FIFO write to head visible).
REQ-016 SHALL update the in-flight count and FIFO count correctly when issue, return, and pop occur in the same cycle; overflow SHALL be unreachable by credit.
REQ-017 SHALL ignore mem_rdata_valid when the in-flight count is 0 (protocol error, no state change).

Reset
REQ-018 SHALL, on rst=1 at a clock edge, clear the in-flight count, both queues, and the priority pointer (to 0).
REQ-019 SHALL drive all ready, valid, and mem_req_valid outputs to 0 during reset, and drive data outputs to 0.
REQ-020 SHALL discard in-flight loads when reset is asserted mid-operation; later mem_rdata_valid pulses are ignored per REQ-017.

Configuration
REQ-021 SHALL, with LSQ_ARB_ROUND_ROBIN_EN defined, grant the first valid requester at or after the pointer (wrapping), then set the pointer to grant+1 mod total on handshake; it is unchanged otherwise.
REQ-022 SHALL, without LSQ_ARB_ROUND_ROBIN_EN, use fixed priority with lowest index first and no pointer register.

Structure
REQ-023 SHALL place the clog2 function, port-ID width, and the response entry type in shared package lsq_arb_pkg.
REQ-024 SHALL implement both queues with one sub-module, lsq_arb_fifo (parameterised width/depth, simultaneous push/pop).

Verification
REQ-025 SHALL cover: rst then idle -> all ready/valid outputs 0, mem_req_valid=0.
REQ-026 SHALL cover: load0 addr 0x10 valid, mem_req_ready=1, rdata 0xAB next cycle -> load_data_valid_bus=01 with data 0xAB one cycle after return.
REQ-027 SHALL cover (round-robin build): loads 0, 1 and store 2 all valid continuously -> grant order 0,1,2,0.
REQ-028 SHALL cover: DEPTH=4, consumer ready=0, 4 loads issued -> fifth load_ready held 0 until one response is popped.
REQ-029 SHALL cover: load1 then load0 issued, returns 0x11 then 0x22 -> port1 receives 0x11, port0 receives 0x22.
REQ-030 SHALL cover: rst asserted with 2 loads in flight, then 2 mem_rdata_valid pulses -> no load_data_valid asserted.
